// File: rtl/xorshift_stream.sv
// Flow-controlled xorshift generator: each beat carries LANES consecutive generator
// outputs; commands reseed or continue from the held state, abort cancels, done pulses.
module xorshift_stream #(
  parameter int WIDTH       = 32,
  parameter int LANES       = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [WIDTH-1:0]       seed,
  input  logic                   reuse_state,
  input  logic [COUNT_WIDTH-1:0] beat_count,
  input  logic                   abort,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int SH_A = 13;
  localparam int SH_B = (WIDTH == 32) ? 17 : 7;
  localparam int SH_C = (WIDTH == 32) ? 5 : 17;
  localparam logic [WIDTH-1:0] GUARD = (WIDTH == 32) ? WIDTH'(32'h9E3779B9)
                                                     : WIDTH'(64'h9E3779B97F4A7C15);

  if (!(WIDTH == 32 || WIDTH == 64)) begin : g_bad_width
    $error("xorshift_stream: WIDTH must be 32 or 64");
  end
  if (LANES < 1 || LANES > 16) begin : g_bad_lanes
    $error("xorshift_stream: LANES must be in 1..16");
  end

  function automatic logic [WIDTH-1:0] xs_step(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] t;
    t = s ^ (s << SH_A);
    t = t ^ (t >> SH_B);
    t = t ^ (t << SH_C);
    return t;
  endfunction

  // A zero state is a fixed point of xorshift, so it is never allowed into the generator.
  function automatic logic [WIDTH-1:0] guard_zero(input logic [WIDTH-1:0] s);
    return (s == {WIDTH{1'b0}}) ? GUARD : s;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       gen_q, gen_d, gen_adv_s;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [LANES*WIDTH-1:0] data_q, data_d, beat_s;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  always_comb begin
    logic [WIDTH-1:0] w_v;
    w_v    = gen_q;
    beat_s = {(LANES*WIDTH){1'b0}};
    for (int i = 0; i < LANES; i++) begin
      w_v = xs_step(w_v);
      beat_s[i*WIDTH +: WIDTH] = w_v;
    end
    gen_adv_s = w_v;
  end

  always_comb begin
    state_d = state_q;
    gen_d   = gen_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_LOAD;
          cnt_d   = beat_count;
          gen_d   = reuse_state ? guard_zero(gen_q) : guard_zero(seed);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end else if (cnt_q == {COUNT_WIDTH{1'b0}}) begin
          state_d = ST_DONE;
        end else begin
          data_d  = beat_s;
          valid_d = 1'b1;
          gen_d   = gen_adv_s;
          cnt_d   = cnt_q - COUNT_WIDTH'(1);
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        // cnt_q counts beats still to be presented after the one on the bus.
        if (abort) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end else if (valid_q && out_ready) begin
          if (cnt_q != {COUNT_WIDTH{1'b0}}) begin
            data_d = beat_s;
            gen_d  = gen_adv_s;
            cnt_d  = cnt_q - COUNT_WIDTH'(1);
          end else begin
            valid_d = 1'b0;
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gen_q   <= {WIDTH{1'b0}};
      cnt_q   <= {COUNT_WIDTH{1'b0}};
      data_q  <= {(LANES*WIDTH){1'b0}};
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gen_q   <= gen_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_xorshift_stream.sv
// Bench for xorshift_stream: a 32-bit/2-lane instance with a 4-bit count field and a
// 64-bit/1-lane instance, checked against a word-sequence model of the generator.
module tb_xorshift_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, reuse_state, abort, out_ready;
  logic [31:0] seed;
  logic [3:0]  beat_count;
  logic [63:0] out_data;
  logic        out_valid, busy, done;

  logic        start_w, reuse_w, abort_w, ready_w;
  logic [63:0] seed_w;
  logic [15:0] cnt_w;
  logic [63:0] data_w;
  logic        valid_w, busy_w, done_w;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_s;
  logic [63:0] m_w;

  xorshift_stream #(.WIDTH(32), .LANES(2), .COUNT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .reuse_state(reuse_state),
    .beat_count(beat_count), .abort(abort), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  xorshift_stream #(.WIDTH(64), .LANES(1), .COUNT_WIDTH(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .start(start_w), .seed(seed_w), .reuse_state(reuse_w),
    .beat_count(cnt_w), .abort(abort_w), .out_data(data_w), .out_valid(valid_w),
    .out_ready(ready_w), .busy(busy_w), .done(done_w)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] st32(input logic [31:0] x);
    x = x ^ (x << 13);
    x = x ^ (x >> 17);
    x = x ^ (x << 5);
    return x;
  endfunction

  function automatic logic [63:0] st64(input logic [63:0] x);
    x = x ^ (x << 13);
    x = x ^ (x >> 7);
    x = x ^ (x << 17);
    return x;
  endfunction

  function automatic logic [31:0] grd32(input logic [31:0] x);
    return (x == 32'h0) ? 32'h9E3779B9 : x;
  endfunction

  function automatic logic [63:0] grd64(input logic [63:0] x);
    return (x == 64'h0) ? 64'h9E3779B97F4A7C15 : x;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Next two words of the sequence, lane 0 in the low half.
  task automatic take_beat(output logic [63:0] b);
    for (int i = 0; i < 2; i++) begin
      m_s = st32(m_s);
      b[i*32 +: 32] = m_s;
    end
  endtask

  // mode: 0 ready always high, 1 random ready, 2 ready pattern 1,0,0,1,1 then high.
  task automatic stream_cmd(input logic [31:0] sd, input bit reuse, input int cnt,
                            input int mode, input string nm);
    logic [63:0] exp_b;
    logic [4:0]  pat;
    int          got, dones, cyc;
    bit          v, rdy;
    pat   = 5'b11001;
    exp_b = 64'h0;
    got   = 0;
    dones = 0;
    cyc   = 0;
    m_s   = reuse ? grd32(m_s) : grd32(sd);
    seed = sd; reuse_state = reuse; beat_count = 4'(cnt); start = 1'b1;
    tick;
    start = 1'b0;
    if (cnt > 0) take_beat(exp_b);
    while (dones == 0 && cyc < 8 * cnt + 20) begin
      v = out_valid;
      if (v) begin
        total++;
        if (got >= cnt || out_data !== exp_b) begin
          bad++;
          $display("FAIL %s beat %0d: data=%h, expected %h (beats %0d of %0d)",
                   nm, got, out_data, exp_b, got, cnt);
        end
      end
      if (done === 1'b1) begin
        dones = 1;
      end else begin
        case (mode)
          0: rdy = 1'b1;
          1: rdy = 1'($urandom_range(0, 1));
          default: rdy = (cyc < 5) ? pat[cyc] : 1'b1;
        endcase
        out_ready = rdy;
        tick;
        cyc++;
        if (v && rdy) begin
          got++;
          if (got < cnt) take_beat(exp_b);
        end
      end
    end
    total++;
    if (dones != 1 || got != cnt) begin
      bad++;
      $display("FAIL %s end: beats=%0d done_seen=%0d, expected beats=%0d done_seen=1",
               nm, got, dones, cnt);
    end
    out_ready = 1'b1;
    tick;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s idle: done=%b busy=%b valid=%b, expected 0 0 0", nm, done, busy, out_valid);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; seed = 32'h0; reuse_state = 1'b0; beat_count = 4'd0;
    abort = 1'b0; out_ready = 1'b1;
    start_w = 1'b0; seed_w = 64'h0; reuse_w = 1'b0; cnt_w = 16'd0; abort_w = 1'b0; ready_w = 1'b1;
    tick;
    tick;
    rst_n = 1'b1;
    total++;
    if ({out_data, out_valid, busy, done} !== 67'h0) begin
      bad++;
      $display("FAIL reset32: data=%h valid=%b busy=%b done=%b, expected all 0",
               out_data, out_valid, busy, done);
    end
    total++;
    if ({data_w, valid_w, busy_w, done_w} !== 67'h0) begin
      bad++;
      $display("FAIL reset64: data=%h valid=%b busy=%b done=%b, expected all 0",
               data_w, valid_w, busy_w, done_w);
    end
  endtask

  task automatic test_latency;
    logic [63:0] b;
    m_s = grd32(32'd1);
    seed = 32'd1; reuse_state = 1'b0; beat_count = 4'd1; out_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL lat_load: valid=%b busy=%b, expected 0 1", out_valid, busy);
    end
    tick;
    take_beat(b);
    total++;
    if (out_valid !== 1'b1 || out_data !== 64'h04080601_00042021) begin
      bad++;
      $display("FAIL lat_beat: valid=%b data=%h, expected 1 0408060100042021", out_valid, out_data);
    end
    tick;
    total++;
    if (out_valid !== 1'b0 || done !== 1'b1) begin
      bad++;
      $display("FAIL lat_done: valid=%b done=%b, expected 0 1", out_valid, done);
    end
    tick;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL lat_idle: done=%b busy=%b, expected 0 0", done, busy);
    end
  endtask

  task automatic test_stall;
    stream_cmd(32'd1, 1'b0, 3, 2, "stall");
  endtask

  task automatic test_zero_seed;
    stream_cmd(32'd0, 1'b0, 1, 0, "zero32");
  endtask

  task automatic test_continuation;
    stream_cmd(32'd1, 1'b0, 2, 1, "cont_a");
    stream_cmd(32'hDEADBEEF, 1'b1, 2, 1, "cont_b");
  endtask

  task automatic test_count_zero;
    seed = $urandom; reuse_state = 1'b0; beat_count = 4'd0; start = 1'b1;
    m_s = grd32(seed);
    tick;
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL zero_cnt_load: busy=%b valid=%b done=%b, expected 1 0 0", busy, out_valid, done);
    end
    tick;
    total++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL zero_cnt_done: done=%b valid=%b, expected 1 0", done, out_valid);
    end
    tick;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL zero_cnt_idle: done=%b busy=%b, expected 0 0", done, busy);
    end
    stream_cmd(32'h0, 1'b1, 1, 0, "zero_cnt_cont");
  endtask

  task automatic test_wrap;
    stream_cmd($urandom, 1'b0, 15, 0, "wrap");
  endtask

  task automatic test_abort;
    logic [63:0] b;
    logic [31:0] sd;
    sd = $urandom;
    m_s = grd32(sd);
    seed = sd; reuse_state = 1'b0; beat_count = 4'd5; out_ready = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    take_beat(b);
    tick;
    seed = ~sd; beat_count = 4'd1; start = 1'b1;
    tick;
    start = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== b || busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_stall: valid=%b data=%h busy=%b, expected 1 %h 1", out_valid, out_data, busy, b);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    total++;
    if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_exit: valid=%b done=%b busy=%b, expected 0 0 0", out_valid, done, busy);
    end
    tick;
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL abort_nodone: done=%b, expected 0", done);
    end
    stream_cmd(32'h0, 1'b1, 3, 1, "after_abort");

    sd = $urandom;
    m_s = grd32(sd);
    seed = sd; reuse_state = 1'b0; beat_count = 4'd1; out_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    take_beat(b);
    tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    total++;
    if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_hs: valid=%b done=%b busy=%b, expected 0 0 0", out_valid, done, busy);
    end
    stream_cmd(32'h0, 1'b1, 1, 0, "after_abort_hs");

    seed = $urandom; reuse_state = 1'b0; beat_count = 4'd2; abort = 1'b1; start = 1'b1;
    tick;
    abort = 1'b0; start = 1'b0;
    tick;
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle: busy=%b valid=%b, expected 0 0", busy, out_valid);
    end
    stream_cmd(32'h0, 1'b1, 2, 0, "after_idle_abort");
  endtask

  task automatic test_reset_mid;
    seed = $urandom; reuse_state = 1'b0; beat_count = 4'd4; out_ready = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    total++;
    if ({out_data, out_valid, busy, done} !== 67'h0) begin
      bad++;
      $display("FAIL reset_mid: data=%h valid=%b busy=%b done=%b, expected all 0",
               out_data, out_valid, busy, done);
    end
    m_s = 32'h0;
    out_ready = 1'b1;
    stream_cmd($urandom, 1'b1, 2, 1, "post_reset");
  endtask

  task automatic test_random;
    logic [31:0] sd;
    for (int k = 0; k < 8; k++) begin
      sd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      stream_cmd(sd, 1'($urandom_range(0, 1)), int'($urandom_range(0, 6)), 1, "random");
    end
  endtask

  task automatic test_w64;
    int  got, cyc;
    bit  v, rdy;
    for (int r = 0; r < 2; r++) begin
      m_w = (r == 0) ? grd64(64'h0) : grd64(m_w);
      seed_w = (r == 0) ? 64'h0 : {$urandom, $urandom};
      reuse_w = (r == 1); cnt_w = 16'd3; start_w = 1'b1;
      tick;
      start_w = 1'b0;
      m_w = st64(m_w);
      got = 0;
      cyc = 0;
      while (got < 3 && cyc < 60) begin
        v = valid_w;
        if (v) begin
          total++;
          if (data_w !== m_w) begin
            bad++;
            $display("FAIL w64 run %0d beat %0d: data=%h, expected %h", r, got, data_w, m_w);
          end
        end
        rdy = 1'($urandom_range(0, 1));
        ready_w = rdy;
        tick;
        cyc++;
        if (v && rdy) begin
          got++;
          if (got < 3) m_w = st64(m_w);
        end
      end
      total++;
      if (got != 3 || done_w !== 1'b1) begin
        bad++;
        $display("FAIL w64 run %0d end: beats=%0d done=%b, expected 3 1", r, got, done_w);
      end
      ready_w = 1'b1;
      tick;
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stall();
    test_zero_seed();
    test_continuation();
    test_count_zero();
    test_wrap();
    test_abort();
    test_reset_mid();
    test_random();
    test_w64();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
